// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max-pool stage: one raster pixel in per i_valid,
// one pooled pixel out per completed 2x2 window, no input stall.
module maxpool_2x2 #(
   parameter int IN_WIDTH   = 512,
   parameter int IN_HEIGHT  = 256,
   parameter int IN_CHANNEL = 32,
   parameter int SIGNED     = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [8*IN_CHANNEL-1:0] i_data,
   input  logic                    i_valid,
   input  logic                    fifo_almost_full,
   output logic                    o_fifo_almost_full,
   output logic [8*IN_CHANNEL-1:0] o_data,
   output logic                    o_valid,
   output logic                    o_frame_done
);

   localparam int DW = 8 * IN_CHANNEL;
   localparam int OW = IN_WIDTH / 2;
   localparam int OH = IN_HEIGHT / 2;
   localparam int CW = $clog2(IN_WIDTH);
   localparam int RW = $clog2(IN_HEIGHT);
   localparam int AW = (OW > 1) ? $clog2(OW) : 1;

   // Handshake: i_valid is a push-only strobe (this stage never stalls its
   // producer); o_valid is a push-only write strobe into the downstream FIFO,
   // whose almost-full is forwarded straight back to the conv producer.

   function automatic logic [DW-1:0] vmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < IN_CHANNEL; i++) begin
         if (SIGNED != 0)
            r[i*8 +: 8] = ($signed(a[i*8 +: 8]) > $signed(b[i*8 +: 8])) ? a[i*8 +: 8] : b[i*8 +: 8];
         else
            r[i*8 +: 8] = (a[i*8 +: 8] > b[i*8 +: 8]) ? a[i*8 +: 8] : b[i*8 +: 8];
      end
      return r;
   endfunction

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [DW-1:0] hold;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] pair_max;
   logic [DW-1:0] rowbuf [OW];
   logic [CW-1:0] half_col;
   logic [RW-1:0] half_row;
   logic [AW-1:0] addr;
   logic          col_last;
   logic          row_last;
   logic          rd_in_range;

   assign o_fifo_almost_full = fifo_almost_full;

   assign half_col    = col >> 1;
   assign half_row    = row >> 1;
   assign addr        = AW'(half_col);
   assign col_last    = (col == CW'(IN_WIDTH - 1));
   assign row_last    = (row == RW'(IN_HEIGHT - 1));
   // An odd-width trailing column has no partner, so its read would fall past the buffer.
   assign rd_in_range = (half_col < CW'(OW));
   assign pair_max    = vmax(hold, i_data);

   // Line buffer with synchronous read: written in even rows on odd columns,
   // read in odd rows on even columns, so the two ports never collide.
   always_ff @(posedge clk) begin
      if (i_valid && !col[0] && row[0] && rd_in_range)
         rd_data <= rowbuf[addr];
      if (i_valid && col[0] && !row[0])
         rowbuf[addr] <= pair_max;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col          <= '0;
         row          <= '0;
         hold         <= '0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
         if (i_valid) begin
            if (!col[0]) begin
               hold <= i_data;
            end else if (row[0]) begin
               o_data       <= vmax(rd_data, pair_max);
               o_valid      <= 1'b1;
               o_frame_done <= (half_col == CW'(OW - 1)) && (half_row == RW'(OH - 1));
            end
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Bench for maxpool_2x2: 4x4x2 unsigned/signed pair on shared stimulus and
// a 5x5x1 instance, checked against hand-computed pooled pixels.
module tb_maxpool_2x2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] ab_data;
   logic        ab_valid;
   logic [7:0]  c_data;
   logic        c_valid;
   logic        faf;

   logic        a_faf, a_valid, a_done;
   logic [15:0] a_data;
   logic        b_faf, b_valid, b_done;
   logic [15:0] b_data;
   logic        c_faf, c_valid_o, c_done;
   logic [7:0]  c_data_o;

   maxpool_2x2 #(.IN_WIDTH(4), .IN_HEIGHT(4), .IN_CHANNEL(2), .SIGNED(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_data(ab_data), .i_valid(ab_valid),
      .fifo_almost_full(faf), .o_fifo_almost_full(a_faf),
      .o_data(a_data), .o_valid(a_valid), .o_frame_done(a_done));

   maxpool_2x2 #(.IN_WIDTH(4), .IN_HEIGHT(4), .IN_CHANNEL(2), .SIGNED(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_data(ab_data), .i_valid(ab_valid),
      .fifo_almost_full(faf), .o_fifo_almost_full(b_faf),
      .o_data(b_data), .o_valid(b_valid), .o_frame_done(b_done));

   maxpool_2x2 #(.IN_WIDTH(5), .IN_HEIGHT(5), .IN_CHANNEL(1), .SIGNED(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .i_data(c_data), .i_valid(c_valid),
      .fifo_almost_full(faf), .o_fifo_almost_full(c_faf),
      .o_data(c_data_o), .o_valid(c_valid_o), .o_frame_done(c_done));

   // Entry layout: {expected cycle[31:0], frame_done, data[15:0]}
   logic [48:0] exp_a_q[$];
   logic [48:0] exp_b_q[$];
   logic [48:0] exp_c_q[$];
   logic [48:0] ea_e, eb_e, ec_e;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitors: compare every presented output against the queue head.
   always @(negedge clk) begin
      if (a_valid) begin
         if (exp_a_q.size() == 0) check("a_unexpected_valid", 64'(a_data), 64'hDEAD);
         else begin
            ea_e = exp_a_q.pop_front();
            check("a_cycle", 64'(cyc), 64'(ea_e[48:17]));
            check("a_data", 64'(a_data), 64'(ea_e[15:0]));
            check("a_done", 64'(a_done), 64'(ea_e[16]));
         end
      end else if (a_done) check("a_stray_done", 64'(a_done), 64'(0));
   end

   always @(negedge clk) begin
      if (b_valid) begin
         if (exp_b_q.size() == 0) check("b_unexpected_valid", 64'(b_data), 64'hDEAD);
         else begin
            eb_e = exp_b_q.pop_front();
            check("b_cycle", 64'(cyc), 64'(eb_e[48:17]));
            check("b_data", 64'(b_data), 64'(eb_e[15:0]));
            check("b_done", 64'(b_done), 64'(eb_e[16]));
         end
      end else if (b_done) check("b_stray_done", 64'(b_done), 64'(0));
   end

   always @(negedge clk) begin
      if (c_valid_o) begin
         if (exp_c_q.size() == 0) check("c_unexpected_valid", 64'(c_data_o), 64'hDEAD);
         else begin
            ec_e = exp_c_q.pop_front();
            check("c_cycle", 64'(cyc), 64'(ec_e[48:17]));
            check("c_data", 64'(c_data_o), 64'(ec_e[15:0]));
            check("c_done", 64'(c_done), 64'(ec_e[16]));
         end
      end else if (c_done) check("c_stray_done", 64'(c_done), 64'(0));
   end

   logic [15:0] f1[16];
   logic [15:0] f2[16];
   logic [15:0] e1[4];
   logic [15:0] e2u[4];
   logic [15:0] e2s[4];
   logic [15:0] ec1[4];
   logic [15:0] ec2[4];

   task automatic send_ab(input logic [15:0] px[16], input logic [15:0] ea[4],
                          input logic [15:0] eb[4], input int npx, input int max_gap);
      for (int k = 0; k < npx; k++) begin
         int r, c, w;
         r = k / 4;
         c = k % 4;
         repeat ($urandom_range(0, max_gap)) begin
            @(negedge clk);
            ab_valid = 1'b0;
         end
         @(negedge clk);
         ab_data  = px[k];
         ab_valid = 1'b1;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            w = (r / 2) * 2 + c / 2;
            exp_a_q.push_back({32'(cyc + 1), (w == 3), ea[w]});
            exp_b_q.push_back({32'(cyc + 1), (w == 3), eb[w]});
         end
      end
   endtask

   task automatic send_c(input int base, input logic [15:0] ec[4], input int max_gap);
      for (int k = 0; k < 25; k++) begin
         int r, c, w;
         r = k / 5;
         c = k % 5;
         repeat ($urandom_range(0, max_gap)) begin
            @(negedge clk);
            c_valid = 1'b0;
         end
         @(negedge clk);
         c_data  = 8'(base + k);
         c_valid = 1'b1;
         if ((r % 2 == 1) && (c % 2 == 1) && (r < 4) && (c < 4)) begin
            w = (r / 2) * 2 + c / 2;
            exp_c_q.push_back({32'(cyc + 1), (w == 3), ec[w]});
         end
      end
   endtask

   task automatic idle_all();
      @(negedge clk);
      ab_valid = 1'b0;
      c_valid  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ab_valid = 1'b0;
      c_valid  = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("a_rst_valid", 64'(a_valid), 64'(0));
      check("a_rst_data",  64'(a_data),  64'(0));
      check("a_rst_done",  64'(a_done),  64'(0));
      check("b_rst_valid", 64'(b_valid), 64'(0));
      check("b_rst_data",  64'(b_data),  64'(0));
      check("c_rst_valid", 64'(c_valid_o), 64'(0));
      check("c_rst_data",  64'(c_data_o),  64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         if (exp_a_q.size() == 0 && exp_b_q.size() == 0 && exp_c_q.size() == 0) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("a_drain_left", 64'(exp_a_q.size()), 64'(0));
      check("b_drain_left", 64'(exp_b_q.size()), 64'(0));
      check("c_drain_left", 64'(exp_c_q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      ab_data  = '0;
      ab_valid = 1'b0;
      c_data   = '0;
      c_valid  = 1'b0;
      faf      = 1'b0;

      // Frame 1: ch0 = p, ch1 = 15 - p.
      for (int k = 0; k < 16; k++) f1[k] = {8'(15 - k), 8'(k)};
      e1[0] = 16'h0F05; e1[1] = 16'h0D07; e1[2] = 16'h070D; e1[3] = 16'h050F;

      // Frame 2: windows where signed and unsigned ordering disagree.
      f2[0]  = 16'h7F80; f2[1]  = 16'h00FF; f2[4]  = 16'h01FB; f2[5]  = 16'h02FE;
      f2[2]  = 16'hC010; f2[3]  = 16'hC190; f2[6]  = 16'h3F05; f2[7]  = 16'h007F;
      f2[8]  = 16'h0000; f2[9]  = 16'h0000; f2[12] = 16'h0000; f2[13] = 16'h0000;
      f2[10] = 16'hFFFF; f2[11] = 16'hFFFF; f2[14] = 16'hFFFF; f2[15] = 16'hFFFF;
      e2u[0] = 16'h7FFF; e2u[1] = 16'hC190; e2u[2] = 16'h0000; e2u[3] = 16'hFFFF;
      e2s[0] = 16'h7FFF; e2s[1] = 16'h3F7F; e2s[2] = 16'h0000; e2s[3] = 16'hFFFF;

      ec1[0] = 16'd6;   ec1[1] = 16'd8;   ec1[2] = 16'd16;  ec1[3] = 16'd18;
      ec2[0] = 16'd106; ec2[1] = 16'd108; ec2[2] = 16'd116; ec2[3] = 16'd118;

      do_reset();

      // Back-to-back frames: continuous, then with random gaps.
      send_ab(f1, e1, e1, 16, 0);
      send_ab(f2, e2u, e2s, 16, 2);
      idle_all();
      drain();

      // Odd dimensions: trailing column and row are dropped.
      send_c(0, ec1, 0);
      send_c(100, ec2, 2);
      idle_all();
      drain();

      // Partial frame, then reset, then a full frame from (0,0).
      send_ab(f1, e1, e1, 10, 0);
      idle_all();
      drain();
      do_reset();
      repeat (3) idle_all();
      send_ab(f1, e1, e1, 16, 1);
      idle_all();
      drain();

      // Almost-full passthrough.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         faf = 1'($urandom_range(0, 1));
         #1;
         check("a_faf", 64'(a_faf), 64'(faf));
         check("c_faf", 64'(c_faf), 64'(faf));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
